stream_mux_rr: RTL
==================

Name: stream_mux_rr

Overview:
- Parametrised N-channel, DATA_W-bit stream multiplexer. Successor to the 4:1 gate-level mux.
- Adds valid/ready handshakes on every input and on the output.
- Selection is either round-robin arbitration or an external fixed select.
- Single registered output stage; sits between multiple producers and one shared consumer.

Parameters:
- N_CH, 4, number of input channels (>=2).
- DATA_W, 8, data width per channel.
- SEL_W, $clog2(N_CH), select/channel-index width (derived; do not override).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  N_CH*DATA_W  flattened inputs; channel i at bits [i*DATA_W +: DATA_W].
- in_valid  input  N_CH  per-channel valid.
- in_ready  output  N_CH  per-channel ready (combinational).
- sel_mode  input  1  0 = round-robin, 1 = fixed select.
- sel  input  SEL_W  channel used when sel_mode=1.
- out_data  output  DATA_W  registered output data.
- out_ch  output  SEL_W  index of the channel that produced out_data.
- out_valid  output  1  output valid.
- out_ready  input  1  consumer ready.

Behaviour:
- Reset values: out_valid=0, out_data=0, out_ch=0, rr_ptr=0. in_ready forced to all-zero while rst=1.
- Output register states:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- can_load = ~out_valid | out_ready.
- Grant is one-hot, at most one bit set:
  - Round-robin: first channel with in_valid=1 scanning rr_ptr, rr_ptr+1, ... mod N_CH.
  - Fixed: channel sel only, and only if in_valid[sel]=1. No other channel is ever granted.
- in_ready[i] = grant[i] & can_load & ~rst. A transfer on input i occurs when in_valid[i] & in_ready[i].
- On an input transfer:
  - out_data <= in_data[g].
  - out_ch <= g.
  - out_valid <= 1.
  - In round-robin mode, rr_ptr <= (g+1) mod N_CH, wrapping from N_CH-1 to 0.
- Output consumed with no new transfer: out_valid <= 0 and out_data holds.
- Simultaneous consume and load: the new beat is loaded the same cycle. Back-to-back throughput is 1 beat/cycle.
- Latency: one clock from input transfer to out_valid.
- Output stalled (out_valid=1, out_ready=0): all in_ready=0; out_data/out_ch/out_valid held stable.
- No in_valid asserted (or in_valid[sel]=0 in fixed mode): no grant, rr_ptr unchanged.
- Fixed mode never updates rr_ptr. Switching back to round-robin resumes from the retained rr_ptr.
- sel_mode and sel are sampled every cycle. A change affects only the next grant; the beat already in the output register is unaffected.
- sel >= N_CH (non-power-of-2 N_CH): no grant.
- Reset mid-operation: a pending output beat is discarded and the registers return to their reset values on the next edge.
- Inputs must hold data while valid and not ready. The block does not check this.

Optional Feature:
- Macro: STREAM_MUX_CNT_EN.
- Defined:
  - Adds output port beat_cnt (output, 16 bits).
  - Counts completed output handshakes (out_valid & out_ready); wraps 0xFFFF -> 0.
  - Resets to 0.
  - Saturation is not required.
- Undefined: port and counter are absent. All other behaviour is identical.

Decomposition:
- Package stream_mux_pkg holds:
  - CNT_W = 16.
  - Mode constants MODE_RR = 1'b0 and MODE_FIXED = 1'b1.
  - The function for rotated priority index arithmetic.
- One sub-module: rr_arbiter (parameter N_CH).
  - Inputs: req, ptr. Output: one-hot grant.
  - Purely combinational, reused by the fixed-mode bypass mux.

Test Plan:
- Reset: assert rst 2 cycles with all in_valid=1 -> in_ready=0, out_valid=0, out_data=0 throughout; first grant after release is ch0.
- Round-robin fairness: N_CH=4, all in_valid=1, out_ready=1, data = 0xA0+ch -> out_ch sequence 0,1,2,3,0,1,... at one beat per cycle; out_data 0xA0, 0xA1, 0xA2, 0xA3.
- Sparse requests / wrap:
  - Only ch1 and ch3 valid, rr_ptr=2 -> ch3 granted first, then ch1.
  - rr_ptr wraps 3 -> 0.
- Backpressure: out_ready=0 for 5 cycles with beat 0x5C from ch2 held -> out_data=0x5C and out_ch=2 stable, all in_ready=0. Release -> 0x5C consumed and the next beat loaded the same cycle.
- Fixed mode:
  - sel_mode=1, sel=2, all valid -> only ch2 transfers; in_ready[0,1,3]=0.
  - Switching to sel=0 mid-stream -> next beat from ch0. Beat in flight still reports out_ch=2.
- STREAM_MUX_CNT_EN:
  - 70000 handshakes -> beat_cnt = 70000 mod 65536 = 4464.
  - Stalled cycles do not increment the count.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared constants and index helper for the round-robin stream multiplexer.
package stream_mux_pkg;

  localparam int unsigned CNT_W = 16;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  // Channel index reached by stepping 'off' places from 'base', modulo n.
  function automatic int unsigned rot_idx(input int unsigned base,
                                          input int unsigned off,
                                          input int unsigned n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter: one-hot grant to the first
// requester found scanning from ptr upwards, wrapping modulo N_CH.
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter int unsigned N_CH  = 4,
  localparam int unsigned SEL_W = $clog2(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N_CH-1:0]  grant
);

  // Scan requesters in rotated order and keep only the first hit.
  always_comb begin
    logic             found;
    logic [SEL_W-1:0] idx;
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      idx = SEL_W'(rot_idx(32'(ptr), k, N_CH));
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with a single registered output
// stage. Selection is round-robin or an external fixed select.
// Optional beat counter output enabled by defining STREAM_MUX_CNT_EN.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int unsigned N_CH   = 4,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SEL_W  = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH*DATA_W-1:0] in_data,
  input  logic [N_CH-1:0]        in_valid,
  output logic [N_CH-1:0]        in_ready,
  input  logic                   sel_mode,
  input  logic [SEL_W-1:0]       sel,
  output logic [DATA_W-1:0]      out_data,
  output logic [SEL_W-1:0]       out_ch,
  output logic                   out_valid,
  input  logic                   out_ready
`ifdef STREAM_MUX_CNT_EN
  ,
  output logic [CNT_W-1:0]       beat_cnt
`endif
);

  // Output register occupancy; the valid flag is the state.
  localparam logic StEmpty = 1'b0;
  localparam logic StFull  = 1'b1;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0]  out_ch_q, out_ch_d;
  logic [SEL_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic [N_CH-1:0]   sel_mask;
  logic [N_CH-1:0]   arb_req;
  logic [SEL_W-1:0]  arb_ptr;
  logic [N_CH-1:0]   grant;
  logic [SEL_W-1:0]  gnt_idx;
  logic [DATA_W-1:0] gnt_data;
  logic              can_load;
  logic              load;

  // One-hot decode of sel; out-of-range sel gives an empty mask.
  always_comb begin
    sel_mask = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      sel_mask[i] = (32'(sel) == i);
    end
  end

  // Fixed mode reuses the arbiter with only the selected request visible.
  always_comb begin
    if (sel_mode == MODE_FIXED) begin
      arb_req = in_valid & sel_mask;
      arb_ptr = sel;
    end else begin
      arb_req = in_valid;
      arb_ptr = rr_ptr_q;
    end
  end

  rr_arbiter #(
    .N_CH (N_CH)
  ) u_arb (
    .req   (arb_req),
    .ptr   (arb_ptr),
    .grant (grant)
  );

  // Encode the one-hot grant into an index and pick the granted data.
  always_comb begin
    gnt_idx  = '0;
    gnt_data = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (grant[i]) begin
        gnt_idx  = SEL_W'(i);
        gnt_data = in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign can_load = (out_valid_q == StEmpty) | out_ready;
  assign in_ready = grant & {N_CH{can_load & ~rst}};
  assign load     = |(in_valid & in_ready);

  // Next state for the output register and the round-robin pointer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      out_valid_d = StFull;
      out_data_d  = gnt_data;
      out_ch_d    = gnt_idx;
      if (sel_mode == MODE_RR) begin
        rr_ptr_d = SEL_W'(rot_idx(32'(gnt_idx), 1, N_CH));
      end
    end else if (out_ready) begin
      out_valid_d = StEmpty;
    end
  end

  // State registers with synchronous reset; reset drops any pending beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= StEmpty;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

`ifdef STREAM_MUX_CNT_EN
  logic [CNT_W-1:0] beat_cnt_q;

  // Count completed output handshakes, wrapping naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt_q <= '0;
    end else if (out_valid_q && out_ready) begin
      beat_cnt_q <= beat_cnt_q + 1'b1;
    end
  end

  assign beat_cnt = beat_cnt_q;
`endif

endmodule
